// File: rtl/bcd_seg_scanner.sv
// Time-multiplexed 3-digit common-anode seven-segment scanner fed by a BCD converter.
// Define BCD_LZB_EN to blank leading zeros in the hundreds and tens slots.
//
// state  | meaning
// S_ONES | driving an[0] with display[3:0]
// S_TENS | driving an[1] with display[7:4]
// S_HUND | driving an[2] with display[11:8]; frame commit on its last cycle
module bcd_seg_scanner #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] bcd_bits,
    input  logic        bcd_valid,
    output logic [2:0]  an,
    output logic [6:0]  seg,
    output logic        frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES);

    typedef enum logic [1:0] {
        S_ONES = 2'd0,
        S_TENS = 2'd1,
        S_HUND = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic          tick;
    logic          commit;
    logic [11:0]   pending;
    logic [11:0]   display;
    logic          pending_dirty;
    logic [3:0]    nibble;
    logic [2:0]    an_sel;
    logic          digit_on;
    logic [2:0]    an_next;
    logic [6:0]    seg_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b0000110;
        endcase
    endfunction

    assign tick = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_ONES;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        frame_done = 1'b0;
        commit     = 1'b0;
        case (state)
            S_ONES: if (tick) state_next = S_TENS;
            S_TENS: if (tick) state_next = S_HUND;
            S_HUND: begin
                if (tick) begin
                    state_next = S_ONES;
                    frame_done = 1'b1;
                    commit     = pending_dirty;
                end
            end
            default: state_next = S_ONES;
        endcase
    end

    // A strobe on the commit edge lands in pending and stays dirty; display takes the old pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending       <= '0;
            pending_dirty <= 1'b0;
            display       <= '0;
        end else begin
            if (bcd_valid) begin
                pending       <= bcd_bits;
                pending_dirty <= 1'b1;
            end else if (commit) begin
                pending_dirty <= 1'b0;
            end
            if (commit) begin
                display <= pending;
            end
        end
    end

    always_comb begin
        nibble = display[3:0];
        an_sel = 3'b110;
        case (state)
            S_TENS: begin
                nibble = display[7:4];
                an_sel = 3'b101;
            end
            S_HUND: begin
                nibble = display[11:8];
                an_sel = 3'b011;
            end
            default: begin
                nibble = display[3:0];
                an_sel = 3'b110;
            end
        endcase

        digit_on = (cnt >= CNT_SHOW);
`ifdef BCD_LZB_EN
        // Only a literal zero nibble blanks; invalid codes still show "E".
        if (state == S_HUND && display[11:8] == 4'd0) begin
            digit_on = 1'b0;
        end
        if (state == S_TENS && display[11:8] == 4'd0 && display[7:4] == 4'd0) begin
            digit_on = 1'b0;
        end
`endif
        an_next  = digit_on ? an_sel : 3'b111;
        seg_next = digit_on ? seg_decode(nibble) : 7'b1111111;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 3'b111;
            seg <= 7'b1111111;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Bench for bcd_seg_scanner with REFRESH_DIV=8, BLANK_CYCLES=2; checks every cycle of each frame.
// Build with BCD_LZB_EN defined to check the leading-zero blanking variant.
module tb_bcd_seg_scanner;

    localparam int REFRESH_DIV  = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int FRAME        = 3 * REFRESH_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] bcd_bits = '0;
    logic        bcd_valid = 1'b0;
    logic [2:0]  an;
    logic [6:0]  seg;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         frame;
        logic [6:0] s0;
        logic [6:0] s1;
        logic [6:0] s2;
        logic [2:0] blank;
    } exp_t;

    typedef struct {
        logic [11:0] bcd;
        exp_t        e;
    } vec_t;

    exp_t sb_q[$];
    exp_t cur;
    exp_t zero_e;
    exp_t e255;
    exp_t e456;
    exp_t e789;
    int   frame_no = 0;
    vec_t vecs[8];

    bcd_seg_scanner #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bcd_bits  (bcd_bits),
        .bcd_valid (bcd_valid),
        .an        (an),
        .seg       (seg),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%b required=%b (frame %0d, t=%0t)", name, act, exp, frame_no, $time);
        end
    endtask

    function automatic exp_t mk(input logic [6:0] s0, input logic [6:0] s1,
                                input logic [6:0] s2, input logic [2:0] blank);
        exp_t e;
        e.frame = 0;
        e.s0    = s0;
        e.s1    = s1;
        e.s2    = s2;
        e.blank = blank;
        return e;
    endfunction

    // A strobe on the last slot cycle coincides with the commit, so it shows one frame later.
    task automatic strobe(input int idx, input logic [11:0] bits, input exp_t e);
        exp_t t;
        t         = e;
        t.frame   = frame_no + ((idx == FRAME - 1) ? 2 : 1);
        bcd_bits  = bits;
        bcd_valid = 1'b1;
        if (sb_q.size() > 0 && sb_q[sb_q.size()-1].frame == t.frame)
            sb_q[sb_q.size()-1] = t;
        else
            sb_q.push_back(t);
    endtask

    // Entered one negedge after a frame_done cycle; checks 24 cycles of output.
    task automatic watch_frame(input int i1, input logic [11:0] b1, input exp_t e1,
                               input int i2, input logic [11:0] b2, input exp_t e2);
        int         slot;
        int         c;
        logic       on;
        logic [2:0] ea;
        logic [6:0] es;
        if (sb_q.size() > 0 && sb_q[0].frame == frame_no)
            cur = sb_q.pop_front();
        for (int i = 0; i < FRAME; i++) begin
            bcd_valid = 1'b0;
            if (i == i1) strobe(i, b1, e1);
            if (i == i2) strobe(i, b2, e2);
            @(negedge clk);
            slot = i / REFRESH_DIV;
            c    = i % REFRESH_DIV;
            on   = (c >= BLANK_CYCLES);
`ifdef BCD_LZB_EN
            on   = on && !cur.blank[slot];
`endif
            ea = (slot == 0) ? 3'b110 : (slot == 1) ? 3'b101 : 3'b011;
            if (!on) ea = 3'b111;
            es = (slot == 0) ? cur.s0 : (slot == 1) ? cur.s1 : cur.s2;
            if (!on) es = 7'b1111111;
            check("an", {4'b0, an}, {4'b0, ea});
            check("seg", seg, es);
            check("frame_done", {6'b0, frame_done}, (i == FRAME - 2) ? 7'd1 : 7'd0);
        end
        bcd_valid = 1'b0;
        frame_no++;
    endtask

    // Called at the negedge where rst is released; leaves the bench aligned to a frame start.
    task automatic post_reset_check();
        for (int k = 0; k < FRAME; k++) begin
            if (k < BLANK_CYCLES + 1) begin
                check("rst_release_an", {4'b0, an}, 7'b0000111);
                check("rst_release_seg", seg, 7'b1111111);
            end else if (k <= REFRESH_DIV) begin
                check("first_ones_an", {4'b0, an}, 7'b0000110);
                check("first_ones_seg", seg, 7'b1000000);
            end
            check("first_frame_done", {6'b0, frame_done}, (k == FRAME - 1) ? 7'd1 : 7'd0);
            @(negedge clk);
        end
        sb_q.delete();
        cur      = zero_e;
        frame_no = 0;
    endtask

    initial begin
        zero_e  = mk(7'b1000000, 7'b1000000, 7'b1000000, 3'b110);
        e255    = mk(7'b0010010, 7'b0010010, 7'b0100100, 3'b000);
        e456    = mk(7'b0000010, 7'b0010010, 7'b0011001, 3'b000);
        e789    = mk(7'b0010000, 7'b0000000, 7'b1111000, 3'b000);
        vecs[0] = '{12'h123, mk(7'b0110000, 7'b0100100, 7'b1111001, 3'b000)};
        vecs[1] = '{12'h0A7, mk(7'b1111000, 7'b0000110, 7'b1000000, 3'b100)};
        vecs[2] = '{12'h099, mk(7'b0010000, 7'b0010000, 7'b1000000, 3'b100)};
        vecs[3] = '{12'h007, mk(7'b1111000, 7'b1000000, 7'b1000000, 3'b110)};
        vecs[4] = '{12'h000, mk(7'b1000000, 7'b1000000, 7'b1000000, 3'b110)};
        vecs[5] = '{12'h8F6, mk(7'b0000010, 7'b0000110, 7'b0000000, 3'b000)};
        vecs[6] = '{12'h945, mk(7'b0010010, 7'b0011001, 7'b0010000, 3'b000)};
        vecs[7] = '{12'h010, mk(7'b1000000, 7'b1111001, 7'b1000000, 3'b100)};
        cur = zero_e;

        repeat (3) @(negedge clk);
        check("reset_an", {4'b0, an}, 7'b0000111);
        check("reset_seg", seg, 7'b1111111);
        check("reset_frame_done", {6'b0, frame_done}, 7'd0);
        rst = 1'b0;
        post_reset_check();

        watch_frame(-1, '0, zero_e, -1, '0, zero_e);

        // Each vector strobed mid-frame: current frame unchanged, next frame shows it.
        for (int v = 0; v < 8; v++) begin
            watch_frame(10, vecs[v].bcd, vecs[v].e, -1, '0, zero_e);
            watch_frame(-1, '0, zero_e, -1, '0, zero_e);
        end

        // Back-to-back strobes: the later value wins, 255 never appears.
        watch_frame(4, 12'h255, e255, 5, 12'h099, vecs[2].e);
        watch_frame(-1, '0, zero_e, -1, '0, zero_e);

        // Strobe on the commit edge: 456 commits now, 789 waits one more frame.
        watch_frame(3, 12'h456, e456, FRAME - 1, 12'h789, e789);
        watch_frame(-1, '0, zero_e, -1, '0, zero_e);
        watch_frame(-1, '0, zero_e, -1, '0, zero_e);

        // Async reset while S_TENS, cnt=5.
        repeat (REFRESH_DIV + 5) @(negedge clk);
        check("pre_reset_an", {4'b0, an}, 7'b0000101);
        check("pre_reset_seg", seg, 7'b0000000);
        #2 rst = 1'b1;
        #1;
        check("async_reset_an", {4'b0, an}, 7'b0000111);
        check("async_reset_seg", seg, 7'b1111111);
        check("async_reset_frame_done", {6'b0, frame_done}, 7'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        post_reset_check();
        watch_frame(-1, '0, zero_e, -1, '0, zero_e);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
